controller_fsm_mc: RTL and testbench
====================================

Name: controller_fsm_mc

Overview:
Multi-cycle successor to the single-cycle opcode decoder: a sequenced FETCH/DECODE/EXEC controller with a memory-ready wait handshake, HALT/resume support and illegal-opcode detection. It drives the same datapath strobes (IR, PC, accumulator, register file, ALU select) from a latched opcode and latched flags. Opcode and ALU-select widths are parametrised, and illegal-opcode handling is selectable.

Parameters:
OPCODE_W, 4, opcode input width (>=4); any opcode with nonzero bits above bit 3 is illegal.
SEL_ALU_W, 4, SelALU width (>=4); the low 4 bits carry the ALU opcode and the upper bits are 0.
HALT_ON_ILLEGAL, 0, 0: an illegal opcode executes as NOP and sets Illegal; 1: it also enters HALT.

Ports:
CLK  in  1  clock, rising edge
CLB  in  1  asynchronous reset, active-high
MemReady  in  1  instruction memory data valid
Resume  in  1  leave HALT (level sampled at a clock edge)
Z  in  1  accumulator zero flag
C  in  1  accumulator carry/negative flag
Opcode  in  OPCODE_W  opcode field from the IR / memory bus
LoadIR  out  1  load instruction register
IncPC  out  1  PC <= PC+1
SelPC  out  1  PC source: 0 = register, 1 = immediate
LoadPC  out  1  load PC from SelPC source
LoadReg  out  1  write register from ACC
LoadAcc  out  1  load accumulator
SelAcc  out  2  ACC source: 00 = ALU, 01 = register, 10 = immediate
SelALU  out  SEL_ALU_W  ALU operation
Halted  out  1  state == HALT
Illegal  out  1  sticky illegal-opcode flag
State  out  2  FETCH = 00, DECODE = 01, EXEC = 10, HALT = 11

Behaviour:
- CLB=1 (asynchronous):
  - State <= FETCH.
  - Latched opcode <= 0 (NOP); latched Z/C <= 0; Illegal <= 0.
  - All strobes are 0 while CLB is high.
- Strobes are decoded from state, latched opcode and latched flags, except LoadIR, which is MemReady gated by FETCH.
- Default for every strobe and select in every state: 0.
- FETCH:
  - LoadIR = MemReady.
  - MemReady=1 -> DECODE next; MemReady=0 -> stay in FETCH (wait indefinitely, no other strobes).
- DECODE:
  - Latch Opcode, Z and C.
  - No strobes asserted.
  - -> EXEC.
- EXEC: one-cycle strobes from the latched opcode, then -> FETCH unless noted.
  - 0001 Add, 0010 Sub, 0011 Nor, 1100 SHR, 1011 SHL: LoadAcc=1, SelAcc=00, SelALU=opcode, IncPC=1.
  - 0100 reg->ACC: LoadAcc=1, SelAcc=01, IncPC=1.
  - 0101 ACC->reg: LoadReg=1, IncPC=1.
  - 1101 imm->ACC: LoadAcc=1, SelAcc=10, IncPC=1.
  - 0110 JZ reg: if Zl, then LoadPC=1, SelPC=0, IncPC=0; else IncPC=1.
  - 0111 JZ imm: same as 0110 with SelPC=1.
  - 1000 JC reg: if Cl, then LoadPC=1, SelPC=0; else IncPC=1.
  - 1010 JC imm: same as 1000 with SelPC=1.
  - 0000 NOP: IncPC=1.
  - 1111 HALT: IncPC=1 (so PC points past HALT), -> HALT.
  - Illegal (1001, 1110, or upper bits nonzero): IncPC=1, Illegal <= 1; -> HALT if HALT_ON_ILLEGAL=1, else -> FETCH.
  - LoadPC and IncPC are never both 1.
- HALT:
  - All strobes 0; Halted=1.
  - Resume=1 at a clock edge -> FETCH and clears Illegal.
  - Resume is ignored in every other state.
- Flags are sampled only in DECODE; Z/C changes during EXEC do not alter the branch decision.
- Instruction latency: 3 cycles (FETCH, DECODE, EXEC) when MemReady=1 in the first FETCH cycle; each cycle with MemReady=0 adds 1.
- CLB asserted mid-EXEC aborts the instruction: strobes drop immediately and the PC update is lost.
- Opcode changes outside DECODE have no effect.

Test Plan:
- Reset with CLB=1 mid-EXEC of Add -> strobes 0 asynchronously; State=00, Illegal=0 after release.
- Opcode=0001, MemReady=1 -> State sequence 00, 01, 10, 00; EXEC cycle has LoadAcc=1, SelAcc=00, SelALU=0001, IncPC=1; LoadIR=1 only in cycle 1.
- Opcode=0111 with Z=1 at DECODE, then Z=0 during EXEC -> EXEC has LoadPC=1, SelPC=1, IncPC=0. Repeat with Z=0 at DECODE -> IncPC=1, LoadPC=0.
- MemReady=0 for 3 cycles, then 1 -> FETCH held 4 cycles; LoadIR=1 only in the 4th; EXEC lands in cycle 6.
- Opcode=1111 -> EXEC has IncPC=1, then Halted=1 for 10 cycles with Resume=0. Resume=1 -> next State=00. Resume=1 while in FETCH -> no effect.
- Opcode=1110 with HALT_ON_ILLEGAL=0 -> IncPC=1, Illegal=1, next FETCH. With HALT_ON_ILLEGAL=1 -> HALT; Resume clears Illegal. With OPCODE_W=6, opcode 010001 -> treated as illegal.

Source files
------------

// File: rtl/controller_fsm_mc_if.sv
// Controller <-> datapath/memory bundle: memory handshake, flags and opcode in,
// datapath strobes and status out.
interface controller_fsm_mc_if #(
  parameter int unsigned OPCODE_W  = 4,
  parameter int unsigned SEL_ALU_W = 4
);
  logic                 MemReady;
  logic                 Resume;
  logic                 Z;
  logic                 C;
  logic [OPCODE_W-1:0]  Opcode;
  logic                 LoadIR;
  logic                 IncPC;
  logic                 SelPC;
  logic                 LoadPC;
  logic                 LoadReg;
  logic                 LoadAcc;
  logic [1:0]           SelAcc;
  logic [SEL_ALU_W-1:0] SelALU;
  logic                 Halted;
  logic                 Illegal;
  logic [1:0]           State;

  modport master (
    input  MemReady, Resume, Z, C, Opcode,
    output LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU,
           Halted, Illegal, State
  );

  modport slave (
    output MemReady, Resume, Z, C, Opcode,
    input  LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU,
           Halted, Illegal, State
  );
endinterface

// File: rtl/controller_fsm_mc.sv
// Multi-cycle FETCH/DECODE/EXEC controller with memory-ready wait, HALT/resume
// and sticky illegal-opcode detection; strobes decode from latched opcode/flags.
module controller_fsm_mc #(
  parameter int unsigned OPCODE_W        = 4,
  parameter int unsigned SEL_ALU_W       = 4,
  parameter bit          HALT_ON_ILLEGAL = 1'b0
) (
  input  logic                CLK,
  input  logic                CLB,
  controller_fsm_mc_if.master bus
);

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    DECODE = 2'b01,
    EXEC   = 2'b10,
    HALT   = 2'b11
  } state_t;

  state_t              state;
  state_t              nextState;
  logic [OPCODE_W-1:0] opcodeL;
  logic                zL;
  logic                cL;
  logic                illegalQ;
  logic [3:0]          aluOp;
  logic                opIllegal;

  logic                 loadIR;
  logic                 incPC;
  logic                 selPC;
  logic                 loadPC;
  logic                 loadReg;
  logic                 loadAcc;
  logic [1:0]           selAcc;
  logic [SEL_ALU_W-1:0] selALU;

  assign aluOp     = opcodeL[3:0];
  assign opIllegal = (|(opcodeL >> 4)) || (aluOp == 4'b1001) || (aluOp == 4'b1110);

  // State register
  always_ff @(posedge CLK or posedge CLB) begin
    if (CLB) state <= FETCH;
    else     state <= nextState;
  end

  // Opcode/flag capture in DECODE; sticky illegal flag cleared only by resuming from HALT
  always_ff @(posedge CLK or posedge CLB) begin
    if (CLB) begin
      opcodeL  <= '0;
      zL       <= 1'b0;
      cL       <= 1'b0;
      illegalQ <= 1'b0;
    end else begin
      if (state == DECODE) begin
        opcodeL <= bus.Opcode;
        zL      <= bus.Z;
        cL      <= bus.C;
      end
      if (state == EXEC && opIllegal) illegalQ <= 1'b1;
      else if (state == HALT && bus.Resume) illegalQ <= 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    unique case (state)
      FETCH:  if (bus.MemReady) nextState = DECODE;
      DECODE: nextState = EXEC;
      EXEC: begin
        if (opIllegal)             nextState = HALT_ON_ILLEGAL ? HALT : FETCH;
        else if (aluOp == 4'b1111) nextState = HALT;
        else                       nextState = FETCH;
      end
      HALT:   if (bus.Resume) nextState = FETCH;
    endcase
  end

  // Strobe decode; everything is forced low while reset is asserted
  always_comb begin
    loadIR  = 1'b0;
    incPC   = 1'b0;
    selPC   = 1'b0;
    loadPC  = 1'b0;
    loadReg = 1'b0;
    loadAcc = 1'b0;
    selAcc  = 2'b00;
    selALU  = '0;
    if (!CLB) begin
      unique case (state)
        FETCH:  loadIR = bus.MemReady;
        DECODE: ;
        HALT:   ;
        EXEC: begin
          if (opIllegal) begin
            incPC = 1'b1;
          end else begin
            case (aluOp)
              4'b0001, 4'b0010, 4'b0011, 4'b1100, 4'b1011: begin
                loadAcc = 1'b1;
                selALU  = SEL_ALU_W'(aluOp);
                incPC   = 1'b1;
              end
              4'b0100: begin
                loadAcc = 1'b1;
                selAcc  = 2'b01;
                incPC   = 1'b1;
              end
              4'b0101: begin
                loadReg = 1'b1;
                incPC   = 1'b1;
              end
              4'b1101: begin
                loadAcc = 1'b1;
                selAcc  = 2'b10;
                incPC   = 1'b1;
              end
              4'b0110, 4'b0111: begin
                if (zL) begin
                  loadPC = 1'b1;
                  selPC  = aluOp[0];
                end else begin
                  incPC = 1'b1;
                end
              end
              4'b1000, 4'b1010: begin
                if (cL) begin
                  loadPC = 1'b1;
                  selPC  = aluOp[1];
                end else begin
                  incPC = 1'b1;
                end
              end
              default: incPC = 1'b1;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.LoadIR  = loadIR;
  assign bus.IncPC   = incPC;
  assign bus.SelPC   = selPC;
  assign bus.LoadPC  = loadPC;
  assign bus.LoadReg = loadReg;
  assign bus.LoadAcc = loadAcc;
  assign bus.SelAcc  = selAcc;
  assign bus.SelALU  = selALU;
  assign bus.Halted  = (state == HALT);
  assign bus.Illegal = illegalQ;
  assign bus.State   = state;

endmodule

// File: tb/tb_controller_fsm_mc.sv
// Bench for controller_fsm_mc: two instances (4-bit opcode/no halt on illegal, and
// 6-bit opcode/halt on illegal) against an instruction-level model, plus directed checks.
module tb_controller_fsm_mc;

  logic       CLK = 1'b0;
  logic       CLB = 1'b1;
  logic       MemReady = 1'b0;
  logic       Resume = 1'b0;
  logic       Z = 1'b0;
  logic       C = 1'b0;
  logic [5:0] opB = 6'd0;
  bit         cmpEn = 1'b0;

  int nChecks = 0;
  int nErrors = 0;

  controller_fsm_mc_if #(.OPCODE_W(4), .SEL_ALU_W(4)) ifA ();
  controller_fsm_mc_if #(.OPCODE_W(6), .SEL_ALU_W(5)) ifB ();

  assign ifA.MemReady = MemReady;
  assign ifA.Resume   = Resume;
  assign ifA.Z        = Z;
  assign ifA.C        = C;
  assign ifA.Opcode   = opB[3:0];
  assign ifB.MemReady = MemReady;
  assign ifB.Resume   = Resume;
  assign ifB.Z        = Z;
  assign ifB.C        = C;
  assign ifB.Opcode   = opB;

  controller_fsm_mc #(.OPCODE_W(4), .SEL_ALU_W(4), .HALT_ON_ILLEGAL(1'b0)) dutA (
    .CLK(CLK), .CLB(CLB), .bus(ifA.master)
  );
  controller_fsm_mc #(.OPCODE_W(6), .SEL_ALU_W(5), .HALT_ON_ILLEGAL(1'b1)) dutB (
    .CLK(CLK), .CLB(CLB), .bus(ifB.master)
  );

  always #5 CLK = ~CLK;

  // {State, Halted, Illegal, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU}
  wire [19:0] actA = {ifA.State, ifA.Halted, ifA.Illegal, ifA.LoadIR, ifA.IncPC, ifA.SelPC,
                      ifA.LoadPC, ifA.LoadReg, ifA.LoadAcc, ifA.SelAcc, 8'(ifA.SelALU)};
  wire [19:0] actB = {ifB.State, ifB.Halted, ifB.Illegal, ifB.LoadIR, ifB.IncPC, ifB.SelPC,
                      ifB.LoadPC, ifB.LoadReg, ifB.LoadAcc, ifB.SelAcc, 8'(ifB.SelALU)};

  // Instruction-level model: phase 0 fetch, 1 decode, 2 execute, 3 halted
  int mPhase[2] = '{0, 0};
  int mOp[2]    = '{0, 0};
  bit mZ[2]     = '{0, 0};
  bit mC[2]     = '{0, 0};
  bit mIll[2]   = '{0, 0};

  function automatic bit isIllegal(input int op);
    return ((op >> 4) != 0) || ((op & 15) == 9) || ((op & 15) == 14);
  endfunction

  always @(posedge CLK or posedge CLB) begin
    for (int i = 0; i < 2; i++) begin
      if (CLB) begin
        mPhase[i] = 0; mOp[i] = 0; mZ[i] = 0; mC[i] = 0; mIll[i] = 0;
      end else if (mPhase[i] == 0) begin
        if (MemReady) mPhase[i] = 1;
      end else if (mPhase[i] == 1) begin
        mOp[i] = (i == 0) ? int'(opB[3:0]) : int'(opB);
        mZ[i] = Z; mC[i] = C;
        mPhase[i] = 2;
      end else if (mPhase[i] == 2) begin
        if (isIllegal(mOp[i])) begin
          mIll[i] = 1;
          mPhase[i] = (i == 1) ? 3 : 0;
        end else begin
          mPhase[i] = (mOp[i] == 15) ? 3 : 0;
        end
      end else begin
        if (Resume) begin mPhase[i] = 0; mIll[i] = 0; end
      end
    end
  end

  function automatic logic [19:0] expVec(input int i);
    int op = mOp[i];
    int lo = op & 15;
    logic lir = 0, inc = 0, spc = 0, lpc = 0, lreg = 0, lacc = 0, taken;
    logic [1:0] sacc = 2'b00;
    logic [7:0] salu = 8'd0;
    if (!CLB && mPhase[i] == 0) lir = MemReady;
    if (!CLB && mPhase[i] == 2) begin
      if (isIllegal(op)) inc = 1;
      else if (lo == 1 || lo == 2 || lo == 3 || lo == 11 || lo == 12) begin
        lacc = 1; salu = 8'(lo); inc = 1;
      end else if (lo == 4) begin lacc = 1; sacc = 2'b01; inc = 1; end
      else if (lo == 5) begin lreg = 1; inc = 1; end
      else if (lo == 13) begin lacc = 1; sacc = 2'b10; inc = 1; end
      else if (lo == 6 || lo == 7 || lo == 8 || lo == 10) begin
        taken = (lo < 8) ? mZ[i] : mC[i];
        if (taken) begin lpc = 1; spc = (lo == 7 || lo == 10); end
        else inc = 1;
      end else inc = 1;
    end
    return {2'(mPhase[i]), mPhase[i] == 3, mIll[i], lir, inc, spc, lpc, lreg, lacc, sacc, salu};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of both instances against the model
  always @(negedge CLK) begin
    if (cmpEn) begin
      check("modelA", 32'(actA), 32'(expVec(0)));
      check("modelB", 32'(actB), 32'(expVec(1)));
    end
  end

  task automatic nextDrive();
    @(posedge CLK);
    #2;
  endtask

  // From a FETCH cycle (posedge+2), run fetch and decode, leaving us at the EXEC negedge
  task automatic toExec(input logic [5:0] op, input logic z, input logic c, input logic zLate);
    MemReady = 1; opB = op; Z = z; C = c;
    @(negedge CLK);
    check("fetch_state", 32'(ifA.State), 0);
    check("fetch_loadir", 32'(ifA.LoadIR), 1);
    nextDrive();
    MemReady = 0;
    @(negedge CLK);
    check("decode_state", 32'(ifA.State), 1);
    check("decode_loadir", 32'(ifA.LoadIR), 0);
    nextDrive();
    Z = zLate; C = ~c; opB = ~op;
    @(negedge CLK);
    check("exec_state", 32'(ifA.State), 2);
  endtask

  initial begin
    CLB = 1; MemReady = 1; opB = 6'h01;
    @(posedge CLK);
    cmpEn = 1;
    @(negedge CLK);
    check("reset_loadir", 32'(ifA.LoadIR), 0);
    check("reset_state", 32'(ifA.State), 0);
    check("reset_illegal", 32'(ifA.Illegal), 0);
    check("reset_loadir_b", 32'(ifB.LoadIR), 0);
    nextDrive();
    CLB = 0;

    // Add
    toExec(6'h01, 0, 0, 0);
    check("add_loadacc", 32'(ifA.LoadAcc), 1);
    check("add_selacc", 32'(ifA.SelAcc), 0);
    check("add_selalu", 32'(ifA.SelALU), 1);
    check("add_incpc", 32'(ifA.IncPC), 1);
    check("add_loadir", 32'(ifA.LoadIR), 0);
    nextDrive();
    @(negedge CLK);
    check("add_back_fetch", 32'(ifA.State), 0);
    nextDrive();

    // JZ imm: flags latched in DECODE, later Z changes ignored
    toExec(6'h07, 1, 0, 0);
    check("jz_taken_loadpc", 32'(ifA.LoadPC), 1);
    check("jz_taken_selpc", 32'(ifA.SelPC), 1);
    check("jz_taken_incpc", 32'(ifA.IncPC), 0);
    nextDrive();
    toExec(6'h07, 0, 0, 1);
    check("jz_nt_loadpc", 32'(ifA.LoadPC), 0);
    check("jz_nt_incpc", 32'(ifA.IncPC), 1);
    nextDrive();
    toExec(6'h08, 0, 1, 0);
    check("jc_reg_loadpc", 32'(ifA.LoadPC), 1);
    check("jc_reg_selpc", 32'(ifA.SelPC), 0);
    nextDrive();

    // Memory wait: three not-ready cycles
    MemReady = 0; opB = 6'h00;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("wait_state", 32'(ifA.State), 0);
      check("wait_loadir", 32'(ifA.LoadIR), 0);
      nextDrive();
    end
    MemReady = 1;
    @(negedge CLK);
    check("wait_loadir4", 32'(ifA.LoadIR), 1);
    nextDrive();
    MemReady = 0;
    @(negedge CLK);
    check("wait_decode5", 32'(ifA.State), 1);
    nextDrive();
    @(negedge CLK);
    check("wait_exec6", 32'(ifA.State), 2);
    check("wait_nop_incpc", 32'(ifA.IncPC), 1);
    nextDrive();

    // HALT and resume
    toExec(6'h0F, 0, 0, 0);
    check("halt_incpc", 32'(ifA.IncPC), 1);
    nextDrive();
    Resume = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      check("halted_a", 32'(ifA.Halted), 1);
      check("halted_b", 32'(ifB.State), 3);
      nextDrive();
    end
    Resume = 1;
    nextDrive();
    @(negedge CLK);
    check("resume_state", 32'(ifA.State), 0);
    check("resume_state_b", 32'(ifB.State), 0);
    nextDrive();
    @(negedge CLK);
    check("resume_in_fetch", 32'(ifA.State), 0);
    nextDrive();
    Resume = 0;

    // Illegal 1110: A continues, B halts
    toExec(6'h0E, 0, 0, 0);
    check("ill_incpc_a", 32'(ifA.IncPC), 1);
    check("ill_loadacc_a", 32'(ifA.LoadAcc), 0);
    check("ill_incpc_b", 32'(ifB.IncPC), 1);
    nextDrive();
    @(negedge CLK);
    check("ill_fetch_a", 32'(ifA.State), 0);
    check("ill_flag_a", 32'(ifA.Illegal), 1);
    check("ill_halt_b", 32'(ifB.State), 3);
    check("ill_flag_b", 32'(ifB.Illegal), 1);
    nextDrive();
    Resume = 1;
    nextDrive();
    Resume = 0;
    @(negedge CLK);
    check("ill_clear_b", 32'(ifB.Illegal), 0);
    check("ill_sticky_a", 32'(ifA.Illegal), 1);
    nextDrive();

    // Wide opcode 010001: legal Add on A, illegal on B
    toExec(6'h11, 0, 0, 0);
    check("wide_add_a", 32'(ifA.LoadAcc), 1);
    check("wide_ill_loadacc_b", 32'(ifB.LoadAcc), 0);
    check("wide_ill_incpc_b", 32'(ifB.IncPC), 1);
    nextDrive();
    @(negedge CLK);
    check("wide_halt_b", 32'(ifB.State), 3);
    check("wide_flag_b", 32'(ifB.Illegal), 1);
    nextDrive();
    Resume = 1;
    nextDrive();
    Resume = 0;

    // Reset in the middle of an Add EXEC cycle
    toExec(6'h01, 0, 0, 0);
    check("abort_pre_loadacc", 32'(ifA.LoadAcc), 1);
    #1 CLB = 1;
    #1;
    check("abort_loadacc", 32'(ifA.LoadAcc), 0);
    check("abort_incpc", 32'(ifA.IncPC), 0);
    check("abort_state", 32'(ifA.State), 0);
    nextDrive();
    CLB = 0;
    @(negedge CLK);
    check("abort_illegal", 32'(ifA.Illegal), 0);

    // Randomised traffic
    for (int n = 0; n < 4000; n++) begin
      nextDrive();
      MemReady = ($urandom % 4) != 0;
      Resume   = ($urandom % 8) == 0;
      Z        = 1'($urandom);
      C        = 1'($urandom);
      opB      = (($urandom % 4) == 0) ? 6'($urandom) : {2'b00, 4'($urandom)};
      CLB      = ($urandom % 300) == 0;
    end
    nextDrive();
    CLB = 0;
    @(negedge CLK);
    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
